// File: rtl/emissor_pontos_if.sv
// Handshake bundle between the hand judge, the point emitter and the two placar increment inputs.
interface emissor_pontos_if #(
  parameter int W = 4
);
  logic         Start;
  logic [W-1:0] Valor;
  logic         Time;
  logic         Abort;
  logic         I0;
  logic         I1;
  logic         Busy;
  logic         Done;

  modport master (
    output Start, Valor, Time, Abort,
    input  I0, I1, Busy, Done
  );

  modport slave (
    input  Start, Valor, Time, Abort,
    output I0, I1, Busy, Done
  );
endinterface

// File: rtl/emissor_pontos.sv
// Serialises a hand value into one-cycle increment pulses for the selected team's placar,
// with GAP idle cycles between pulses; reports Busy while awarding and a one-cycle Done.
module emissor_pontos #(
  parameter int W   = 4,
  parameter int GAP = 1
) (
  input  logic             Clk,
  input  logic             Clr,
  emissor_pontos_if.slave  bus
);

  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    cnt_q, cnt_d, cnt_dec;
  logic [GW-1:0]   gap_q, gap_d, gap_dec;
  logic            team_q, team_d;

  assign cnt_dec = cnt_q - W'(1);
  assign gap_dec = gap_q - GW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    team_d  = team_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          cnt_d   = bus.Valor;
          team_d  = bus.Time;
          state_d = (bus.Valor == '0) ? DONE : EMIT;
        end
      end
      EMIT: begin
        // The pulse of this cycle is already on the wire, so an abort only stops later ones.
        if (bus.Abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) begin
            state_d = DONE;
          end else if (GAP == 0) begin
            state_d = EMIT;
          end else begin
            gap_d   = GW'(GAP);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.Abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          gap_d   = '0;
        end else begin
          gap_d = gap_dec;
          if (gap_dec == '0) state_d = EMIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      team_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      team_q  <= team_d;
    end
  end

  // Outputs depend only on registered state, so Clr drops them without a clock edge.
  assign bus.I0   = (state_q == EMIT) && !team_q;
  assign bus.I1   = (state_q == EMIT) &&  team_q;
  assign bus.Busy = (state_q == EMIT) || (state_q == WAIT);
  assign bus.Done = (state_q == DONE);

endmodule

// File: tb/tb_emissor_pontos.sv
// Bench for emissor_pontos: one GAP=1 and one GAP=0 instance, expected output vectors
// queued from the pulse-timing formula at each launch and compared every cycle.
module tb_emissor_pontos;

  logic Clk;
  logic Clr;
  logic mon_en;

  emissor_pontos_if #(.W(4)) b1 ();
  emissor_pontos_if #(.W(4)) b0 ();

  emissor_pontos #(.W(4), .GAP(1)) dut1 (.Clk(Clk), .Clr(Clr), .bus(b1));
  emissor_pontos #(.W(4), .GAP(0)) dut0 (.Clk(Clk), .Clr(Clr), .bus(b0));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;
  int pts [2][2];

  // expected {I0, I1, Busy, Done} per cycle
  logic [3:0] exp1 [$];
  logic [3:0] exp0 [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic void push_v(input bit inst, input logic [3:0] v);
    if (inst) exp1.push_back(v);
    else      exp0.push_back(v);
  endfunction

  function automatic void push_exp(input bit inst, input int n, input int g,
                                   input bit team, input int abort_at);
    int last;
    bit pulse;
    push_v(inst, 4'b0000);
    if (n == 0) begin
      push_v(inst, 4'b0001);
      return;
    end
    last = 1 + (n - 1) * (g + 1);
    for (int c = 1; c <= last; c++) begin
      if (abort_at > 0 && c > abort_at) break;
      pulse = ((c - 1) % (g + 1)) == 0;
      push_v(inst, {pulse & ~team, pulse & team, 1'b1, 1'b0});
    end
    if (abort_at == 0) push_v(inst, 4'b0001);
  endfunction

  always @(negedge Clk) begin
    logic [3:0] e1, e0;
    if (!Clr && mon_en) begin
      e1 = 4'b0000;
      e0 = 4'b0000;
      if (exp1.size() > 0) e1 = exp1.pop_front();
      if (exp0.size() > 0) e0 = exp0.pop_front();
      check("dut1_out", {28'd0, b1.I0, b1.I1, b1.Busy, b1.Done}, {28'd0, e1});
      check("dut0_out", {28'd0, b0.I0, b0.I1, b0.Busy, b0.Done}, {28'd0, e0});
      if (b1.I0) pts[1][0]++;
      if (b1.I1) pts[1][1]++;
      if (b0.I0) pts[0][0]++;
      if (b0.I1) pts[0][1]++;
    end
  end

  task automatic clear_pts();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) pts[i][j] = 0;
  endtask

  task automatic launch(input bit inst, input int n, input bit team,
                        input int abort_at, input bit with_abort);
    if (inst) begin
      b1.Start = 1'b1; b1.Valor = 4'(n); b1.Time = team; b1.Abort = with_abort;
    end else begin
      b0.Start = 1'b1; b0.Valor = 4'(n); b0.Time = team; b0.Abort = with_abort;
    end
    push_exp(inst, n, inst ? 1 : 0, team, abort_at);
    @(posedge Clk); #1;
    // scramble the award inputs after acceptance; they must not matter
    if (inst) begin
      b1.Start = 1'b0; b1.Abort = 1'b0; b1.Valor = ~4'(n); b1.Time = ~team;
    end else begin
      b0.Start = 1'b0; b0.Abort = 1'b0; b0.Valor = ~4'(n); b0.Time = ~team;
    end
  endtask

  task automatic pulse_abort(input bit inst, input int cyc);
    repeat (cyc - 1) @(posedge Clk);
    #1;
    if (inst) b1.Abort = 1'b1; else b0.Abort = 1'b1;
    @(posedge Clk); #1;
    b1.Abort = 1'b0;
    b0.Abort = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    if (exp1.size() == 0 && exp0.size() == 0) @(posedge Clk);
    while ((exp1.size() != 0 || exp0.size() != 0) && i < 400) begin
      @(posedge Clk);
      i++;
    end
    check("drain_timeout", exp1.size() + exp0.size(), 0);
    #1;
  endtask

  task automatic finish_award(input bit inst, input int n, input bit team);
    wait_idle();
    check($sformatf("pts_dut%0d_team%0d", inst, team), pts[inst][team], n);
    check($sformatf("pts_dut%0d_team%0d", inst, !team), pts[inst][!team], 0);
    clear_pts();
  endtask

  initial begin
    Clr = 1'b1;
    mon_en = 1'b0;
    b1.Start = 0; b1.Valor = '0; b1.Time = 0; b1.Abort = 0;
    b0.Start = 0; b0.Valor = '0; b0.Time = 0; b0.Abort = 0;
    clear_pts();
    #2;
    check("rst_out_dut1", {28'd0, b1.I0, b1.I1, b1.Busy, b1.Done}, 0);
    check("rst_out_dut0", {28'd0, b0.I0, b0.I1, b0.Busy, b0.Done}, 0);
    repeat (2) @(posedge Clk);
    #2;
    Clr = 1'b0;
    mon_en = 1'b1;

    launch(1, 3, 0, 0, 0);            // GAP=1: I0 in cycles 1,3,5, Done in 6
    finish_award(1, 3, 0);

    launch(0, 1, 1, 0, 0);            // GAP=0: single I1 pulse
    finish_award(0, 1, 1);

    launch(1, 0, 0, 0, 0);            // zero points: Done next cycle
    finish_award(1, 0, 0);

    launch(1, 6, 0, 0, 0);            // second Start in cycle 4 is ignored
    repeat (3) @(posedge Clk);
    #1;
    b1.Start = 1'b1; b1.Valor = 4'd3;
    @(posedge Clk); #1;
    b1.Start = 1'b0;
    finish_award(1, 6, 0);
    launch(1, 3, 1, 0, 0);            // accepted at the edge ending the IDLE cycle after Done
    finish_award(1, 3, 1);

    launch(1, 9, 0, 5, 0);            // abort at edge ending EMIT cycle 5
    pulse_abort(1, 5);
    finish_award(1, 3, 0);

    launch(1, 4, 1, 2, 0);            // abort during WAIT
    pulse_abort(1, 2);
    finish_award(1, 1, 1);

    launch(1, 2, 0, 0, 1);            // Start and Abort together in IDLE
    finish_award(1, 2, 0);

    launch(0, 4, 0, 0, 0);            // back-to-back pulses
    finish_award(0, 4, 0);

    launch(1, 15, 1, 0, 0);           // maximum award
    finish_award(1, 15, 1);

    launch(1, 12, 0, 0, 0);           // Clr mid-WAIT
    @(posedge Clk); #3;
    Clr = 1'b1;
    #1;
    check("clr_async_dut1", {28'd0, b1.I0, b1.I1, b1.Busy, b1.Done}, 0);
    exp1.delete();
    exp0.delete();
    clear_pts();
    #10;
    Clr = 1'b0;
    wait_idle();
    launch(1, 3, 0, 0, 0);
    finish_award(1, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/emissor_pontos.md
Name: emissor_pontos

Overview:
- Point-award transmitter that drives the increment inputs of the two team scoreboards (placar instances, Time 0 / Time 1).
- A placar adds exactly one point per clock edge on which its increment input is high. This block takes a whole hand value (1, 3, 6, 9, 12 in truco) and serialises it into that many one-cycle increment pulses, separated by a programmable gap.
- It sits between the hand/round judge and the two placar blocks and reports Busy and Done to the judge.

Parameters:
- W, 4, width of the Valor input and of the internal remaining-pulse counter.
- GAP, 1, number of idle cycles inserted between consecutive increment pulses (0 means back-to-back pulses).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Clr  input  1  reset, asynchronous, active-high; forces the block to IDLE with all outputs 0.
- Start  input  1  request to award points; sampled only in IDLE.
- Valor  input  W  number of points to award; captured when Start is accepted.
- Time  input  1  team select: 0 drives I0, 1 drives I1; captured when Start is accepted.
- Abort  input  1  synchronous cancel of an award in progress.
- I0  output  1  increment pulse to the team-0 placar.
- I1  output  1  increment pulse to the team-1 placar.
- Busy  output  1  high while an award is in progress.
- Done  output  1  one-cycle completion strobe.

Behaviour:
- Reset (Clr=1, asynchronous): state=IDLE; remaining count=0; gap counter=0; captured Time=0. I0, I1, Busy and Done are all 0 immediately, without waiting for a clock edge.
- All outputs are registered and are decoded only from state and the captured Time; there are no combinational paths from the inputs to the outputs.
- States:
  - IDLE: if Start=1 at an edge, capture Valor into the count register and Time into the team register. If Valor=0, go to DONE. Otherwise go to EMIT.
  - EMIT: for exactly one cycle, assert I0 (team register=0) or I1 (team register=1); Busy=1. At the edge, decrement the count.
    - If the new count is 0, go to DONE.
    - Else if GAP=0, stay in EMIT.
    - Else load the gap counter with GAP and go to WAIT.
  - WAIT: I0=I1=0, Busy=1. Decrement the gap counter each edge. When it reaches 0, return to EMIT.
  - DONE: Done=1 and Busy=0 for exactly one cycle, then go to IDLE.
- Timing: let Start be accepted at edge t with N=Valor>0.
  - Pulse k (k=0..N-1) is high during cycle t+1+k*(GAP+1).
  - Done is high during cycle t+2+(N-1)*(GAP+1).
- I0 and I1 are never high in the same cycle. Exactly N pulses are emitted per accepted Start, on the captured team only.
- Start is ignored in EMIT, WAIT and DONE; no queueing. The earliest new acceptance is the edge that ends the first IDLE cycle after DONE.
- Changes on Valor or Time after acceptance have no effect on an award in progress.
- Abort=1 at an edge in EMIT or WAIT: go to IDLE. No further pulses are emitted and Done is not asserted. A pulse already high in the current cycle still counts, because placar samples it on that same edge.
- Abort in IDLE or DONE has no effect.
- Start=1 and Abort=1 together in IDLE: Start wins, because Abort is only honoured in EMIT/WAIT.
- Clr mid-award: the award is discarded immediately and the count is cleared. The scoreboards are cleared by their own Clr.
- Valor is unsigned. The maximum award is 2^W-1 pulses, with no saturation. Capping to the game limit is the judge's job.

Test Plan:
- Reset, then Start=1, Valor=3, Time=0, GAP=1 at edge 0 -> I0 high in cycles 1, 3 and 5; I1 never high; Busy high cycles 1-5; Done high in cycle 6 only. A connected placar reads P=3.
- Valor=1, Time=1, GAP=0 -> I1 high in cycle 1; Done in cycle 2; placar1 P=1; I0 stays 0.
- Valor=0 -> no pulses; Done high in cycle 1; Busy stays 0.
- Valor=6, GAP=1, second Start with Valor=3 pulsed in cycle 4 -> exactly 6 pulses, the second Start is ignored, Done in cycle 12. A new Start at the cycle-13 edge is accepted.
- Valor=9, GAP=1, Abort=1 at the edge ending cycle 5 (an EMIT cycle) -> pulses in cycles 1, 3 and 5 only; no Done; IDLE in cycle 6.
- Clr asserted asynchronously mid-WAIT during a Valor=12 award -> I0, I1 and Busy drop to 0 before the next edge. After release, Start with Valor=3 produces exactly 3 pulses.
